// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg: shared definitions for the image-window controller.
//   - command codes carried on the 4-bit cmd port
//   - controller state encoding (also exported on the debug state port)
//   - address-width helper derived from the image geometry
package lcd_ctrl_pkg;

    localparam logic [3:0] CMD_WRITE    = 4'd0;
    localparam logic [3:0] CMD_UP       = 4'd1;
    localparam logic [3:0] CMD_DOWN     = 4'd2;
    localparam logic [3:0] CMD_LEFT     = 4'd3;
    localparam logic [3:0] CMD_RIGHT    = 4'd4;
    localparam logic [3:0] CMD_MAX      = 4'd5;
    localparam logic [3:0] CMD_MIN      = 4'd6;
    localparam logic [3:0] CMD_AVG      = 4'd7;
    localparam logic [3:0] CMD_ROT_CCW  = 4'd8;
    localparam logic [3:0] CMD_ROT_CW   = 4'd9;
    localparam logic [3:0] CMD_MIRROR_X = 4'd10;
    localparam logic [3:0] CMD_MIRROR_Y = 4'd11;
    localparam logic [3:0] CMD_RELOAD   = 4'd12;
    localparam logic [3:0] CMD_HOME     = 4'd13;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } lcd_state_e;

    // Address width for an img_w x img_h image (both powers of two).
    function automatic int lcd_aw(input int img_w, input int img_h);
        return $clog2(img_w * img_h);
    endfunction

endpackage

// File: rtl/lcd_win_alu.sv
// lcd_win_alu: combinational reduction over the four pixels of the 2x2 window.
//   p0_i..p3_i : window pixels (any order)
//   max_o      : largest of the four
//   min_o      : smallest of the four
//   avg_o      : floor(sum/4), sum kept DW+2 bits wide so it never overflows
module lcd_win_alu #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] p0_i,
    input  logic [DW-1:0] p1_i,
    input  logic [DW-1:0] p2_i,
    input  logic [DW-1:0] p3_i,
    output logic [DW-1:0] max_o,
    output logic [DW-1:0] min_o,
    output logic [DW-1:0] avg_o
);

    logic [DW-1:0] mx01, mx23, mn01, mn23;
    logic [DW+1:0] sum;

    always_comb begin
        mx01  = (p0_i > p1_i) ? p0_i : p1_i;
        mx23  = (p2_i > p3_i) ? p2_i : p3_i;
        mn01  = (p0_i < p1_i) ? p0_i : p1_i;
        mn23  = (p2_i < p3_i) ? p2_i : p3_i;
        max_o = (mx01 > mx23) ? mx01 : mx23;
        min_o = (mn01 < mn23) ? mn01 : mn23;
        sum   = {2'b00, p0_i} + {2'b00, p1_i} + {2'b00, p2_i} + {2'b00, p3_i};
        avg_o = sum[DW+1:2];
    end

endmodule

// File: rtl/lcd_ctrl_param.sv
// lcd_ctrl_param: image-window controller.
// Loads an IMG_W x IMG_H image from the ROM into a local buffer, then runs
// commands against a movable 2x2 window and streams the buffer to the RAM on
// a write command.
//   clk, reset        : rising-edge clock, asynchronous active-high reset
//   cmd, cmd_valid    : command code and strobe
//   IROM_Q/rd/A       : ROM read data / read enable / address
//   IRAM_valid/D/A    : RAM write strobe / data / address
//   busy              : high while a command cannot be accepted
//   done              : one-cycle pulse after the last RAM write
//   dbg_state_o       : current controller state (lcd_state_e encoding)
//
// Handshake: a command is taken on a rising edge where cmd_valid=1 and
// busy=0 (which only happens in IDLE). A strobe seen while busy=1 is dropped,
// never queued; busy stays high from the accept edge until the command ends.
module lcd_ctrl_param
    import lcd_ctrl_pkg::*;
#(
    parameter int DW    = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    localparam int AW   = lcd_aw(IMG_W, IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] IROM_Q,
    output logic          IROM_rd,
    output logic [AW-1:0] IROM_A,
    output logic          IRAM_valid,
    output logic [DW-1:0] IRAM_D,
    output logic [AW-1:0] IRAM_A,
    output logic          busy,
    output logic          done,
    output logic [1:0]    dbg_state_o
);

    localparam int N  = IMG_W * IMG_H;
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam int KW = AW + 1;

    localparam logic [RW-1:0] R_HOME = RW'(IMG_H / 2 - 1);
    localparam logic [CW-1:0] C_HOME = CW'(IMG_W / 2 - 1);
    localparam logic [RW-1:0] R_MAX  = RW'(IMG_H - 2);
    localparam logic [CW-1:0] C_MAX  = CW'(IMG_W - 2);
    localparam logic [AW-1:0] A_LAST = AW'(N - 1);
    localparam logic [KW-1:0] K_END  = KW'(N);

    lcd_state_e    state_q, state_d;
    logic [3:0]    cmd_q, cmd_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          irom_rd_q, irom_rd_d;
    logic [AW-1:0] irom_a_q, irom_a_d;
    logic          iram_valid_q, iram_valid_d;
    logic [AW-1:0] iram_a_q, iram_a_d;
    logic [DW-1:0] iram_d_q, iram_d_d;
    logic [RW-1:0] r0_q, r0_d;
    logic [CW-1:0] c0_q, c0_d;
    // One bit wider than an address so the "all N pixels sent" step is visible.
    logic [KW-1:0] k_q, k_d;

    logic [DW-1:0] buf_q [N];

    // Window geometry. Because IMG_W is a power of two, the pixel address is
    // simply the row index concatenated with the column index.
    logic [RW-1:0] r1;
    logic [CW-1:0] c1;
    logic [AW-1:0] a_ul, a_ur, a_ll, a_lr;
    logic [DW-1:0] p_ul, p_ur, p_ll, p_lr;

    assign r1   = r0_q + RW'(1);
    assign c1   = c0_q + CW'(1);
    assign a_ul = {r0_q, c0_q};
    assign a_ur = {r0_q, c1};
    assign a_ll = {r1, c0_q};
    assign a_lr = {r1, c1};
    assign p_ul = buf_q[a_ul];
    assign p_ur = buf_q[a_ur];
    assign p_ll = buf_q[a_ll];
    assign p_lr = buf_q[a_lr];

    logic [DW-1:0] w_max, w_min, w_avg;

    lcd_win_alu #(.DW(DW)) u_alu (
        .p0_i  (p_ul),
        .p1_i  (p_ur),
        .p2_i  (p_ll),
        .p3_i  (p_lr),
        .max_o (w_max),
        .min_o (w_min),
        .avg_o (w_avg)
    );

    // Buffer write controls produced by the next-state logic.
    logic          load_we;
    logic          win_we;
    logic [DW-1:0] nv_ul, nv_ur, nv_ll, nv_lr;

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        irom_rd_d    = irom_rd_q;
        irom_a_d     = irom_a_q;
        iram_valid_d = iram_valid_q;
        iram_a_d     = iram_a_q;
        iram_d_d     = iram_d_q;
        r0_d         = r0_q;
        c0_d         = c0_q;
        k_d          = k_q;
        load_we      = 1'b0;
        win_we       = 1'b0;
        nv_ul        = p_ul;
        nv_ur        = p_ur;
        nv_ll        = p_ll;
        nv_lr        = p_lr;

        case (state_q)
            ST_LOAD: begin
                load_we = 1'b1;
                if (irom_a_q == A_LAST) begin
                    irom_rd_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    irom_a_d = irom_a_q + AW'(1);
                end
            end

            ST_IDLE: begin
                if (cmd_valid && !busy_q) begin
                    cmd_d   = cmd;
                    busy_d  = 1'b1;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                case (cmd_q)
                    CMD_WRITE: begin
                        busy_d  = 1'b1;
                        state_d = ST_WRITE;
                        k_d     = '0;
                    end
                    CMD_UP:    if (r0_q != '0)   r0_d = r0_q - RW'(1);
                    CMD_DOWN:  if (r0_q < R_MAX) r0_d = r1;
                    CMD_LEFT:  if (c0_q != '0)   c0_d = c0_q - CW'(1);
                    CMD_RIGHT: if (c0_q < C_MAX) c0_d = c1;
                    CMD_MAX: begin
                        win_we = 1'b1;
                        nv_ul  = w_max;
                        nv_ur  = w_max;
                        nv_ll  = w_max;
                        nv_lr  = w_max;
                    end
                    CMD_MIN: begin
                        win_we = 1'b1;
                        nv_ul  = w_min;
                        nv_ur  = w_min;
                        nv_ll  = w_min;
                        nv_lr  = w_min;
                    end
                    CMD_AVG: begin
                        win_we = 1'b1;
                        nv_ul  = w_avg;
                        nv_ur  = w_avg;
                        nv_ll  = w_avg;
                        nv_lr  = w_avg;
                    end
                    CMD_ROT_CCW: begin
                        win_we = 1'b1;
                        nv_ul  = p_ur;
                        nv_ur  = p_lr;
                        nv_lr  = p_ll;
                        nv_ll  = p_ul;
                    end
                    CMD_ROT_CW: begin
                        win_we = 1'b1;
                        nv_ul  = p_ll;
                        nv_ll  = p_lr;
                        nv_lr  = p_ur;
                        nv_ur  = p_ul;
                    end
                    CMD_MIRROR_X: begin
                        win_we = 1'b1;
                        nv_ul  = p_ll;
                        nv_ll  = p_ul;
                        nv_ur  = p_lr;
                        nv_lr  = p_ur;
                    end
                    CMD_MIRROR_Y: begin
                        win_we = 1'b1;
                        nv_ul  = p_ur;
                        nv_ur  = p_ul;
                        nv_ll  = p_lr;
                        nv_lr  = p_ll;
                    end
                    CMD_RELOAD: begin
                        // Buffer and origin are left alone; the load overwrites pixels.
                        busy_d    = 1'b1;
                        state_d   = ST_LOAD;
                        irom_a_d  = '0;
                        irom_rd_d = 1'b1;
                    end
                    CMD_HOME: begin
                        r0_d = R_HOME;
                        c0_d = C_HOME;
                    end
                    default: ;
                endcase
            end

            ST_WRITE: begin
                if (k_q == K_END) begin
                    // Address/data hold their last values after the stream.
                    iram_valid_d = 1'b0;
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    iram_valid_d = 1'b1;
                    iram_a_d     = k_q[AW-1:0];
                    iram_d_d     = buf_q[k_q[AW-1:0]];
                    k_d          = k_q + KW'(1);
                end
            end

            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_LOAD;
            cmd_q        <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            irom_rd_q    <= 1'b1;
            irom_a_q     <= '0;
            iram_valid_q <= 1'b0;
            iram_a_q     <= '0;
            iram_d_q     <= '0;
            r0_q         <= R_HOME;
            c0_q         <= C_HOME;
            k_q          <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            irom_rd_q    <= irom_rd_d;
            irom_a_q     <= irom_a_d;
            iram_valid_q <= iram_valid_d;
            iram_a_q     <= iram_a_d;
            iram_d_q     <= iram_d_d;
            r0_q         <= r0_d;
            c0_q         <= c0_d;
            k_q          <= k_d;
        end
    end

    // The four window addresses are always distinct, so the writes never collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            if (load_we) begin
                buf_q[irom_a_q] <= IROM_Q;
            end
            if (win_we) begin
                buf_q[a_ul] <= nv_ul;
                buf_q[a_ur] <= nv_ur;
                buf_q[a_ll] <= nv_ll;
                buf_q[a_lr] <= nv_lr;
            end
        end
    end

    assign IROM_rd     = irom_rd_q;
    assign IROM_A      = irom_a_q;
    assign IRAM_valid  = iram_valid_q;
    assign IRAM_A      = iram_a_q;
    assign IRAM_D      = iram_d_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/lcd_ctrl_param.md
# lcd_ctrl_param

Parametrised image-window controller: bulk-loads a W×H, DW-bit pixel image from the image ROM into an internal buffer and applies handshaked commands to a movable 2×2 window. Commands are shift, max/min/avg fill, rotate and mirror. A write command streams the buffer to the image RAM. After a write the block accepts further commands, and a reload command re-reads the ROM.

## Interface
- DW, 8, pixel width in bits
- IMG_W, 8, image width in pixels; power of two, ≥2
- IMG_H, 8, image height in pixels; power of two, ≥2
- derived: N = IMG_W·IMG_H, AW = log2(N)
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-high
- cmd  in  4  command code, sampled with cmd_valid
- cmd_valid  in  1  command strobe
- IROM_Q  in  DW  ROM read data, valid for IROM_A in the same cycle
- IROM_rd  out  1  ROM read enable
- IROM_A  out  AW  ROM address
- IRAM_valid  out  1  RAM write strobe
- IRAM_D  out  DW  RAM write data
- IRAM_A  out  AW  RAM write address
- busy  out  1  high = command not accepted
- done  out  1  one-cycle pulse at end of write-out

## Operation
- Pixel (row r, col c) is at address r·IMG_W + c. The window origin (r0, c0) covers pixels (r0, c0), (r0, c0+1), (r0+1, c0) and (r0+1, c0+1).
- Reset values:
  - state LOAD; IROM_rd=1, IROM_A=0, busy=1, done=0.
  - IRAM_valid=0, IRAM_A=0, IRAM_D=0; buffer all 0.
  - origin = (IMG_H/2−1, IMG_W/2−1), i.e. address 27 for 8×8.
- States LOAD, IDLE, EXEC, WRITE.
- LOAD: each edge stores buf[IROM_A] ← IROM_Q.
  - If IROM_A < N−1, IROM_A increments.
  - At IROM_A = N−1: IROM_rd←0, busy←0, state→IDLE. IROM_A holds N−1.
  - cmd_valid is ignored during LOAD.
- IDLE: an edge with cmd_valid=1 and busy=0 latches cmd, sets busy←1, state→EXEC.
- EXEC: one edge performs the latched command.
  - Then busy←0, state→IDLE, except for codes 0 and 12.
  - 0 write: state→WRITE, write counter k=0.
  - 1 up: r0−1 if r0>0. 2 down: r0+1 if r0<IMG_H−2.
  - 3 left: c0−1 if c0>0. 4 right: c0+1 if c0<IMG_W−2.
  - An out-of-range shift is a no-op, but the handshake still completes.
  - 5 max, 6 min: all four window pixels ← max/min of the four.
  - 7 avg: all four ← floor(sum/4). Sum is DW+2 bits unsigned, and the result is sum[DW+1:2].
  - 8 rotate CCW: UL←UR, UR←LR, LR←LL, LL←UL.
  - 9 rotate CW: UL←LL, LL←LR, LR←UR, UR←UL.
  - 10 mirror X: swap UL↔LL, UR↔LR. 11 mirror Y: swap UL↔UR, LL↔LR.
  - All four pixels of a window op update on the same edge from pre-edge values.
  - 12 reload: IROM_A←0, IROM_rd←1, state→LOAD. busy stays 1; buffer and origin are unchanged until overwritten.
  - 13 home: origin ← reset origin.
  - 14, 15: no-op.
- WRITE: each edge drives IRAM_valid←1, IRAM_A←k, IRAM_D←buf[k], then k+1.
  - The edge after k=N−1 is driven: IRAM_valid←0, done←1, busy←0, state→IDLE.
  - IRAM_A and IRAM_D hold their last values. done←0 on the next edge.

## Timing
- Load: busy falls on edge N after reset release. The first edge counts as edge 1.
- Command accepted at edge E0 (busy=1 visible after E0). Executed at E1, busy=0 after E1, so the next accept is no earlier than E2.
- Write: first IRAM_valid after E2, N valid cycles, done and busy=0 after edge E1+N+1.
- cmd_valid while busy=1 is dropped, not queued.
- cmd_valid simultaneous with the busy-falling edge is not accepted, because busy was 1 at that edge.
- Reset asserted mid-LOAD/EXEC/WRITE: all outputs immediately take reset values and load restarts from address 0 after release.

## Structure
- Package lcd_ctrl_pkg holds:
  - command code constants (CMD_WRITE … CMD_HOME);
  - the state enum;
  - a clog2-based AW helper.
- Sub-module lcd_win_alu: combinational. Takes four DW-bit pixels and outputs max, min and avg. Parametrised by DW.
- Window addresses are computed from (r0, c0) with widths log2(IMG_H) and log2(IMG_W), never by address-mask comparisons.

## Test plan
- 8×8, ROM[a]=a: busy falls 64 cycles after reset. write → IRAM_A 0..63 with D=A, done pulse of one cycle, then busy=0.
- Default origin 27; avg with pixels 27, 28, 35, 36 → all four = 31 (sum 126).
- Max after rotate CW: pixels 27/28/35/36 become 35/27/36/28; then max sets all four to 36.
- 6× left from reset origin: c0 stops at 0, busy still toggles each command. 10× down: r0 stops at 6 (address 48).
- IMG_W=16, IMG_H=4, DW=10, all ROM=1023: avg gives 1023 (no overflow). Reset origin = (1,7) = address 23.
- Reset asserted at write cycle 20 → IRAM_valid=0, busy=1, IROM_A=0 immediately. Reload mid-session restores the original ROM data while the origin is kept.
